// File: rtl/biriscv_fuzz_pkg.sv
// Shared types and helpers for the biRISCV data-memory bridge: sequencer
// states, request classification and the byte-merge used by partial stores.
package biriscv_fuzz_pkg;

    // Width of the extra-latency counter; LATENCY must fit in it (0..15).
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        WR_ISSUE,
        DELAY,
        ACK
    } state_e;

    typedef enum logic [2:0] {
        LOAD,
        STORE_FULL,
        STORE_PART,
        CMD,
        ERR
    } req_kind_e;

    // Byte i of the result comes from new_word when be[i] is set, else from old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Sort an accepted request into the path it takes through the sequencer.
    // Loads and stores must be word aligned, and a load may not carry byte-enables.
    function automatic req_kind_e classify(input logic       rd,
                                           input logic [3:0] wr,
                                           input logic [1:0] addr_lo);
        logic is_mem;
        is_mem = rd || (wr != 4'h0);
        if ((rd && (wr != 4'h0)) || (is_mem && (addr_lo != 2'b00))) begin
            return ERR;
        end
        if (rd) begin
            return LOAD;
        end
        if (wr == 4'hF) begin
            return STORE_FULL;
        end
        if (wr != 4'h0) begin
            return STORE_PART;
        end
        return CMD;
    endfunction

endpackage

// File: rtl/biriscv_dmem_bridge_if.sv
// Signal bundle between the core's tagged data port, the bridge and the flat
// word-wide memory model. The bridge uses the slave view; the environment
// (core plus memory model) uses the master view.
interface biriscv_dmem_bridge_if #(
    parameter int TAG_W = 11
);
    // Core-side request
    logic [31:0]      mem_addr_i;
    logic [31:0]      mem_data_wr_i;
    logic             mem_rd_i;
    logic [3:0]       mem_wr_i;
    logic             mem_cacheable_i;
    logic [TAG_W-1:0] mem_req_tag_i;
    logic             mem_invalidate_i;
    logic             mem_writeback_i;
    logic             mem_flush_i;

    // Core-side response
    logic             mem_accept_o;
    logic             mem_ack_o;
    logic             mem_error_o;
    logic [31:0]      mem_data_rd_o;
    logic [TAG_W-1:0] mem_resp_tag_o;

    // Model-side request/response
    logic [31:0]      m_req_addr_o;
    logic [31:0]      m_req_data_o;
    logic             m_req_valid_o;
    logic [3:0]       m_req_write_en_o;
    logic             m_resp_valid_i;
    logic [31:0]      m_resp_data_i;

    modport slave (
        input  mem_addr_i, mem_data_wr_i, mem_rd_i, mem_wr_i, mem_cacheable_i,
               mem_req_tag_i, mem_invalidate_i, mem_writeback_i, mem_flush_i,
               m_resp_valid_i, m_resp_data_i,
        output mem_accept_o, mem_ack_o, mem_error_o, mem_data_rd_o, mem_resp_tag_o,
               m_req_addr_o, m_req_data_o, m_req_valid_o, m_req_write_en_o
    );

    modport master (
        output mem_addr_i, mem_data_wr_i, mem_rd_i, mem_wr_i, mem_cacheable_i,
               mem_req_tag_i, mem_invalidate_i, mem_writeback_i, mem_flush_i,
               m_resp_valid_i, m_resp_data_i,
        input  mem_accept_o, mem_ack_o, mem_error_o, mem_data_rd_o, mem_resp_tag_o,
               m_req_addr_o, m_req_data_o, m_req_valid_o, m_req_write_en_o
    );

endinterface

// File: rtl/biriscv_dmem_bridge.sv
// Single-outstanding sequencer between the biRISCV data port and the fuzzing
// memory model. Partial stores become read-modify-write so the model only
// sees whole-word writes; illegal requests and maintenance commands complete
// without touching the model. Every ack is delayed by LATENCY extra cycles.
module biriscv_dmem_bridge
    import biriscv_fuzz_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    biriscv_dmem_bridge_if.slave  bus
);

    // Counter value on the last DELAY cycle; DELAY is bypassed when LATENCY is 0.
    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam state_e           AFTER_ACCESS = (LATENCY == 0) ? ACK : DELAY;

    state_e           state_q, state_d;
    req_kind_e        kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [3:0]       be_q, be_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      rdata_q, rdata_d;   // word captured from the model
    logic [31:0]      maddr_q, maddr_d;   // last address driven to the model

    logic req_present;
    logic in_issue;

    // Cacheability hint and model response-valid carry no behaviour here.
    logic unused_inputs;
    assign unused_inputs = bus.mem_cacheable_i ^ bus.m_resp_valid_i;

    assign req_present = bus.mem_rd_i || (bus.mem_wr_i != 4'h0) || bus.mem_invalidate_i
                      || bus.mem_writeback_i || bus.mem_flush_i;
    assign in_issue    = (state_q == RD_ISSUE) || (state_q == WR_ISSUE);

    // Next-state and request-latch logic.
    always_comb begin
        // NOTE: every variable gets its hold value first so no branch can leave it unassigned and infer a latch.
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        tag_d   = tag_q;
        rdata_d = rdata_q;
        maddr_d = in_issue ? addr_q : maddr_q;

        unique case (state_q)
            IDLE: begin
                if (req_present) begin
                    kind_d = classify(bus.mem_rd_i, bus.mem_wr_i, bus.mem_addr_i[1:0]);
                    addr_d = bus.mem_addr_i;
                    data_d = bus.mem_data_wr_i;
                    be_d   = bus.mem_wr_i;
                    tag_d  = bus.mem_req_tag_i;
                    cnt_d  = '0;
                    unique case (kind_d)
                        LOAD, STORE_PART: state_d = RD_ISSUE;
                        STORE_FULL:       state_d = WR_ISSUE;
                        default:          state_d = AFTER_ACCESS;
                    endcase
                end
            end
            RD_ISSUE: begin
                state_d = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                rdata_d = bus.m_resp_data_i;
                state_d = (kind_q == STORE_PART) ? WR_ISSUE : AFTER_ACCESS;
            end
            WR_ISSUE: begin
                state_d = AFTER_ACCESS;
            end
            DELAY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any request in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst_i) begin
            state_q <= IDLE;
            kind_q  <= CMD;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            tag_q   <= '0;
            rdata_q <= '0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            tag_q   <= tag_d;
            rdata_q <= rdata_d;
            maddr_q <= maddr_d;
        end
    end

    // Output decode from the registered state; writes exist only in WR_ISSUE.
    always_comb begin
        bus.mem_accept_o     = (state_q == IDLE) && !rst_i;
        bus.mem_ack_o        = (state_q == ACK);
        bus.mem_error_o      = (state_q == ACK) && (kind_q == ERR);
        bus.mem_data_rd_o    = ((state_q == ACK) && (kind_q == LOAD)) ? rdata_q : 32'h0;
        bus.mem_resp_tag_o   = (state_q == ACK) ? tag_q : '0;
        bus.m_req_valid_o    = in_issue || (state_q == RD_CAPTURE);
        bus.m_req_addr_o     = in_issue ? addr_q : maddr_q;
        bus.m_req_write_en_o = (state_q == WR_ISSUE) ? 4'hF : 4'h0;
        bus.m_req_data_o     = (state_q == WR_ISSUE) ? merge_bytes(rdata_q, data_q, be_q) : 32'h0;
    end

endmodule

// File: tb/tb_biriscv_dmem_bridge.sv
// Bench for biriscv_dmem_bridge: two bridges (LATENCY 2 and 0) each drive a
// small word memory model. A shadow memory plus per-kind completion rules
// predict ack timing, tag, error, load data and write activity.
module tb_biriscv_dmem_bridge;

    localparam int TAG_W = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    biriscv_dmem_bridge_if #(.TAG_W(TAG_W)) bus_l2();
    biriscv_dmem_bridge_if #(.TAG_W(TAG_W)) bus_l0();

    biriscv_dmem_bridge #(.LATENCY(2), .TAG_W(TAG_W)) u_dut_l2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_l2)
    );

    biriscv_dmem_bridge #(.LATENCY(0), .TAG_W(TAG_W)) u_dut_l0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_l0)
    );

    // Stimulus; sel_l0 routes the request to the LATENCY=0 bridge.
    logic             sel_l0;
    logic             rd_r, inv_r, wb_r, fl_r, cach_r;
    logic [3:0]       wr_r;
    logic [31:0]      addr_r, data_r;
    logic [TAG_W-1:0] tag_r;

    assign bus_l2.mem_addr_i       = addr_r;
    assign bus_l2.mem_data_wr_i    = data_r;
    assign bus_l2.mem_req_tag_i    = tag_r;
    assign bus_l2.mem_cacheable_i  = cach_r;
    assign bus_l2.mem_rd_i         = rd_r  & ~sel_l0;
    assign bus_l2.mem_wr_i         = wr_r  & {4{~sel_l0}};
    assign bus_l2.mem_invalidate_i = inv_r & ~sel_l0;
    assign bus_l2.mem_writeback_i  = wb_r  & ~sel_l0;
    assign bus_l2.mem_flush_i      = fl_r  & ~sel_l0;
    assign bus_l2.m_resp_valid_i   = 1'b0;

    assign bus_l0.mem_addr_i       = addr_r;
    assign bus_l0.mem_data_wr_i    = data_r;
    assign bus_l0.mem_req_tag_i    = tag_r;
    assign bus_l0.mem_cacheable_i  = cach_r;
    assign bus_l0.mem_rd_i         = rd_r  & sel_l0;
    assign bus_l0.mem_wr_i         = wr_r  & {4{sel_l0}};
    assign bus_l0.mem_invalidate_i = inv_r & sel_l0;
    assign bus_l0.mem_writeback_i  = wb_r  & sel_l0;
    assign bus_l0.mem_flush_i      = fl_r  & sel_l0;
    assign bus_l0.m_resp_valid_i   = 1'b0;

    // Observed outputs of whichever bridge is selected.
    logic             obs_accept, obs_ack, obs_err, obs_valid;
    logic [31:0]      obs_rdata, obs_maddr;
    logic [TAG_W-1:0] obs_tag;
    logic [3:0]       obs_we;
    assign obs_accept = sel_l0 ? bus_l0.mem_accept_o     : bus_l2.mem_accept_o;
    assign obs_ack    = sel_l0 ? bus_l0.mem_ack_o        : bus_l2.mem_ack_o;
    assign obs_err    = sel_l0 ? bus_l0.mem_error_o      : bus_l2.mem_error_o;
    assign obs_rdata  = sel_l0 ? bus_l0.mem_data_rd_o    : bus_l2.mem_data_rd_o;
    assign obs_tag    = sel_l0 ? bus_l0.mem_resp_tag_o   : bus_l2.mem_resp_tag_o;
    assign obs_valid  = sel_l0 ? bus_l0.m_req_valid_o    : bus_l2.m_req_valid_o;
    assign obs_we     = sel_l0 ? bus_l0.m_req_write_en_o : bus_l2.m_req_write_en_o;
    assign obs_maddr  = sel_l0 ? bus_l0.m_req_addr_o     : bus_l2.m_req_addr_o;

    // Initial memory image; word 0x60 (byte 0x180) is the RMW target.
    function automatic logic [31:0] seed_word(input int s, input int i);
        if (i == 'h60) return 32'h1122_3344;
        return (32'(i) * 32'h9E37_79B1) ^ ((s != 0) ? 32'h5A5A_0000 : 32'h0000_C3C3);
    endfunction

    // Memory models: read data registered one edge after the address.
    logic        seed_en;
    logic [31:0] mem_l2 [256];
    logic [31:0] mem_l0 [256];
    logic [31:0] rq_l2, rq_l0;

    always @(posedge clk) begin
        if (seed_en) begin
            for (int i = 0; i < 256; i++) mem_l2[i] <= seed_word(0, i);
        end else if (bus_l2.m_req_write_en_o == 4'hF) begin
            mem_l2[bus_l2.m_req_addr_o[9:2]] <= bus_l2.m_req_data_o;
        end
        rq_l2 <= mem_l2[bus_l2.m_req_addr_o[9:2]];
    end

    always @(posedge clk) begin
        if (seed_en) begin
            for (int i = 0; i < 256; i++) mem_l0[i] <= seed_word(1, i);
        end else if (bus_l0.m_req_write_en_o == 4'hF) begin
            mem_l0[bus_l0.m_req_addr_o[9:2]] <= bus_l0.m_req_data_o;
        end
        rq_l0 <= mem_l0[bus_l0.m_req_addr_o[9:2]];
    end

    assign bus_l2.m_resp_data_i = rq_l2;
    assign bus_l0.m_resp_data_i = rq_l0;

    // Reference memory contents, per bridge.
    logic [31:0] ref_mem [2][256];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic clear_req();
        rd_r  = 1'b0;
        wr_r  = 4'h0;
        inv_r = 1'b0;
        wb_r  = 1'b0;
        fl_r  = 1'b0;
    endtask

    // Wait (bounded) for accept on the selected bridge, then present one request.
    task automatic present(input bit s, input logic rd, input logic [3:0] wr,
                           input logic inv, input logic wb, input logic fl,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [TAG_W-1:0] tag, input string name, output bit ok);
        int waited;
        @(negedge clk);
        sel_l0 = s;
        #1;
        waited = 0;
        while (!obs_accept && waited < 32) begin
            @(negedge clk);
            waited++;
        end
        chk({name, " accept"}, 32'(obs_accept), 32'h1);
        ok = obs_accept;
        if (ok) begin
            rd_r   = rd;
            wr_r   = wr;
            inv_r  = inv;
            wb_r   = wb;
            fl_r   = fl;
            addr_r = addr;
            data_r = data;
            tag_r  = tag;
            cach_r = 1'($urandom);
        end
    endtask

    // One complete transaction checked against the completion rules.
    task automatic run_req(input bit s, input logic rd, input logic [3:0] wr,
                           input logic inv, input logic wb, input logic fl,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [TAG_W-1:0] tag, input string name);
        int          lat, exp_cyc, exp_we, idx;
        bit          exp_err, exp_touch, ok;
        logic [31:0] exp_data, w;
        int          ack_cnt, ack_cyc, we_cnt, bad_we, val_cnt, acc_cnt;
        logic [31:0] got_data;
        logic [TAG_W-1:0] got_tag;
        logic        got_err;

        lat       = s ? 0 : 2;
        idx       = int'(addr[9:2]);
        exp_err   = (rd && wr != 4'h0) || ((rd || wr != 4'h0) && addr[1:0] != 2'b00);
        exp_data  = 32'h0;
        exp_we    = 0;
        exp_touch = 1'b0;
        if (exp_err) begin
            exp_cyc = 1 + lat;
        end else if (rd) begin
            exp_cyc   = 3 + lat;
            exp_data  = ref_mem[s][idx];
            exp_touch = 1'b1;
        end else if (wr != 4'h0) begin
            w = ref_mem[s][idx];
            for (int b = 0; b < 4; b++) if (wr[b]) w[8*b +: 8] = data[8*b +: 8];
            ref_mem[s][idx] = w;
            exp_we    = 1;
            exp_touch = 1'b1;
            exp_cyc   = (wr == 4'hF) ? 2 + lat : 4 + lat;
        end else begin
            exp_cyc = 1 + lat;
        end

        present(s, rd, wr, inv, wb, fl, addr, data, tag, name, ok);
        if (!ok) return;

        @(posedge clk);
        ack_cnt = 0; ack_cyc = -1; we_cnt = 0; bad_we = 0; val_cnt = 0; acc_cnt = 0;
        got_data = '0; got_tag = '0; got_err = 1'b0;
        for (int k = 1; k <= exp_cyc + 1; k++) begin
            @(negedge clk);
            if (k == 1) clear_req();
            #1;
            if (k <= exp_cyc && obs_accept) acc_cnt++;
            if (obs_we == 4'hF) we_cnt++;
            else if (obs_we != 4'h0) bad_we++;
            if (obs_valid) val_cnt++;
            if (obs_ack) begin
                ack_cnt++;
                ack_cyc  = k;
                got_data = obs_rdata;
                got_tag  = obs_tag;
                got_err  = obs_err;
            end
        end
        chk({name, " ack count"},   32'(ack_cnt), 32'd1);
        chk({name, " ack cycle"},   32'(ack_cyc), 32'(exp_cyc));
        chk({name, " resp tag"},    32'(got_tag), 32'(tag));
        chk({name, " error"},       32'(got_err), 32'(exp_err));
        chk({name, " read data"},   got_data,     exp_data);
        chk({name, " we pulses"},   32'(we_cnt),  32'(exp_we));
        chk({name, " bad we"},      32'(bad_we),  32'd0);
        chk({name, " model used"},  32'(val_cnt != 0), 32'(exp_touch));
        chk({name, " busy accept"}, 32'(acc_cnt), 32'd0);
        chk({name, " re-accept"},   32'(obs_accept), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int we_seen, ack_seen;
        bit ok;
        sel_l0 = 1'b0;
        cach_r = 1'b0;
        addr_r = '0;
        data_r = '0;
        tag_r  = '0;
        clear_req();
        for (int i = 0; i < 256; i++) begin
            ref_mem[0][i] = seed_word(0, i);
            ref_mem[1][i] = seed_word(1, i);
        end

        // Reset values while reset is held.
        seed_en = 1'b1;
        rst     = 1'b1;
        #1;
        chk("reset accept", 32'(obs_accept), 32'h0);
        chk("reset ack",    32'(obs_ack),    32'h0);
        chk("reset maddr",  obs_maddr,       32'h0);
        chk("reset we",     32'(obs_we),     32'h0);
        chk("reset valid",  32'(obs_valid),  32'h0);
        chk("reset tag",    32'(obs_tag),    32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        seed_en = 1'b0;
        rst     = 1'b0;
        #1;
        chk("post-reset accept", 32'(obs_accept), 32'h1);

        // Directed: loads, full store, partial store, errors, commands.
        run_req(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 11'h5A, "load 0x100");
        run_req(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 11'h5A, "reload 0x100");
        run_req(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h200, 32'hDEAD_BEEF, 11'h12, "full store");
        run_req(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 11'h13, "load 0x200");
        chk("store data shadow", ref_mem[0][32'h200 >> 2], 32'hDEAD_BEEF);
        run_req(1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 32'h180, 32'h0000_AB00, 11'h21, "partial store");
        run_req(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h180, 32'h0, 11'h22, "load 0x180");
        chk("rmw shadow", ref_mem[0][32'h180 >> 2], 32'h1122_AB44);
        run_req(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h102, 32'h0, 11'h31, "misaligned load");
        run_req(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h55, 11'h32, "rd with wr");
        run_req(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 11'h7, "flush L0");
        run_req(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 11'h41, "invalidate");
        run_req(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 11'h42, "writeback");
        run_req(1'b1, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 32'h180, 32'hAA00_00BB, 11'h43, "partial L0");
        run_req(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h180, 32'h0, 11'h44, "load L0 0x180");

        // Reset during RD_CAPTURE of a partial store: nothing written, no ack.
        present(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 32'h0C0, 32'h0000_00EE, 11'h51, "rst mid rmw", ok);
        we_seen  = 0;
        ack_seen = 0;
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
            clear_req();
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("rst mid accept", 32'(obs_accept), 32'h0);
            chk("rst mid maddr",  obs_maddr,       32'h0);
            for (int k = 0; k < 3; k++) begin
                if (obs_we != 4'h0) we_seen++;
                if (obs_ack) ack_seen++;
                @(negedge clk);
                #1;
            end
            rst = 1'b0;
            for (int k = 0; k < 8; k++) begin
                #1;
                if (obs_we != 4'h0) we_seen++;
                if (obs_ack) ack_seen++;
                @(negedge clk);
            end
            #1;
            chk("rst mid we",      32'(we_seen),    32'd0);
            chk("rst mid ack",     32'(ack_seen),   32'd0);
            chk("rst mid re-acc",  32'(obs_accept), 32'h1);
        end
        run_req(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0C0, 32'h0, 11'h52, "load after rst");

        // Randomized traffic across both bridges.
        for (int n = 0; n < 60; n++) begin
            bit          s;
            int          kind;
            logic [31:0] a, d;
            logic [3:0]  be;
            logic [TAG_W-1:0] t;
            s    = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 5));
            a    = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            d    = $urandom;
            t    = TAG_W'($urandom);
            case (kind)
                0: run_req(s, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, a, d, t, "rand load");
                1: run_req(s, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, a, d, t, "rand full");
                2: begin
                    be = 4'($urandom_range(1, 14));
                    run_req(s, 1'b0, be, 1'b0, 1'b0, 1'b0, a, d, t, "rand part");
                end
                3: begin
                    case ($urandom_range(0, 2))
                        0:       run_req(s, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, a, d, t, "rand inv");
                        1:       run_req(s, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, a, d, t, "rand wb");
                        default: run_req(s, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, a, d, t, "rand flush");
                    endcase
                end
                4: begin
                    a[1:0] = 2'($urandom_range(1, 3));
                    if ($urandom_range(0, 1) == 0)
                        run_req(s, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, a, d, t, "rand mis rd");
                    else
                        run_req(s, 1'b0, 4'($urandom_range(1, 15)), 1'b0, 1'b0, 1'b0, a, d, t, "rand mis wr");
                end
                default: run_req(s, 1'b1, 4'($urandom_range(1, 15)), 1'b0, 1'b0, 1'b0, a, d, t, "rand rd+wr");
            endcase
        end

        // Final readback of a few words on both bridges.
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'(i * 'h40 + 'h100), 32'h0, 11'h60, "final L2");
            run_req(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'(i * 'h40 + 'h100), 32'h0, 11'h61, "final L0");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/biriscv_dmem_bridge.md
# biriscv_dmem_bridge

Adapter between the biRISCV core's tagged data-memory port (accept/ack handshake, byte-enables, cache-maintenance commands) and the fuzzing memory model's flat word-wide request/response port. Converts partial-word stores into read-modify-write sequences, so the model only ever sees whole-word writes. Flags misaligned and illegal requests, and returns tagged acks after a configurable extra latency. It is a single-outstanding sequencer located directly upstream of the memory model.

## Interface
- LATENCY, default 2: extra ack delay cycles (0..15) inserted after the memory access.
- TAG_W, default 11: request/response tag width.
- clk_i  in  1: clock.
- rst_i  in  1: reset, asynchronous, active-high.
- mem_addr_i  in  32: core request byte address.
- mem_data_wr_i  in  32: store data.
- mem_rd_i  in  1: load request.
- mem_wr_i  in  4: store byte-enables.
- mem_cacheable_i  in  1: ignored; no behavioural effect.
- mem_req_tag_i  in  TAG_W: request tag.
- mem_invalidate_i, mem_writeback_i, mem_flush_i  in  1 each: maintenance commands.
- mem_accept_o  out  1: request taken this cycle.
- mem_ack_o  out  1: one-cycle completion pulse.
- mem_error_o  out  1: valid with ack; request was illegal.
- mem_data_rd_o  out  32: load data, valid with ack.
- mem_resp_tag_o  out  TAG_W: tag of the completing request.
- m_req_addr_o  out  32: model address.
- m_req_data_o  out  32: model write data.
- m_req_valid_o  out  1: high during issue states.
- m_req_write_en_o  out  4: only ever 4'h0 or 4'hF.
- m_resp_valid_i  in  1: unused; tie-off is legal.
- m_resp_data_i  in  32: model read data, registered by the model one edge after the address.

## Operation
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, DELAY, ACK.
- IDLE
  - mem_accept_o=1 in IDLE only.
  - A request is any of: rd, wr≠0, invalidate, writeback, flush.
  - On an accepted request, latch addr, data, wr, tag and the request kind.
- Routing from IDLE:
  - rd: RD_ISSUE → RD_CAPTURE → DELAY.
  - wr=4'hF: WR_ISSUE → DELAY.
  - wr partial (≠0, ≠F): RD_ISSUE → RD_CAPTURE → WR_ISSUE → DELAY.
  - Maintenance command: DELAY, with no model access.
  - Error: DELAY, with no model access and error flag set. An error is rd together with wr≠0, or addr[1:0]≠0 on rd/wr.
- Issue states:
  - RD_ISSUE drives the latched addr, write_en=0.
  - RD_CAPTURE registers m_resp_data_i.
  - WR_ISSUE drives addr, write_en=4'hF, data=merge. For each byte i, merge takes byte i from the store data if wr[i] is set, otherwise from the captured word.
- DELAY counts LATENCY cycles; with LATENCY=0 it is skipped.
- ACK asserts mem_ack_o for exactly one cycle, along with tag, error and read data (0 for non-loads and errors), then returns to IDLE.
- Outside WR_ISSUE, m_req_write_en_o=0 and m_req_addr_o holds its last driven value. This stops spurious model reads from allocating new addresses.
- Reset (asynchronous, at any point including mid-sequence)
  - State→IDLE, counter→0, pending request discarded, no ack.
  - Output reset values: mem_accept_o=0 while reset is asserted, then 1 on the first cycle in IDLE.
  - All other outputs, including m_req_addr_o, are 0.
  - A write in progress is suppressed immediately.

## Timing
- Cycle 0 is the cycle a request is accepted (accept=1 and request high).
- Ack cycle:
  - load: 3+LATENCY
  - full store: 2+LATENCY
  - partial store: 4+LATENCY
  - command or error: 1+LATENCY
- Model sampling:
  - Load: the model samples the read address at the end of cycle 1; the bridge captures data at the end of cycle 2.
  - Partial store: the model commits at the end of cycle 3; full store at the end of cycle 1.
- Exactly one outstanding request; mem_accept_o=0 from cycle 1 through the ack cycle. The minimum request spacing is therefore ack cycle + 1.
- Requests presented while accept=0 are ignored; the core holds them.

## Structure
- Shared package biriscv_fuzz_pkg holds:
  - the state enum;
  - the request-kind enum (LOAD, STORE_FULL, STORE_PART, CMD, ERR);
  - the LATENCY counter width constant (4);
  - the function merge_bytes(old, new, be).
- No sub-module; one flat sequential block plus combinational output decode.

## Test plan
- Load, LATENCY=2, addr 0x100, tag 0x5A: ack in cycle 5, tag 0x5A, data equals the model word at 0x100, error=0. A repeat load returns the same value.
- Full store 0xDEADBEEF to 0x200, then load 0x200: store ack in cycle 4 with write_en=4'hF seen once; the load returns 0xDEADBEEF.
- Partial store wr=4'b0010, data 0x0000AB00, over word 0x11223344: ack in cycle 6; a later load returns 0x1122AB44.
- Misaligned load at 0x102, and rd with wr=4'h1 at 0x300: ack in cycle 3 with error=1, data 0, no model write_en pulse.
- flush_i with tag 0x7, LATENCY=0: ack in cycle 1, error=0, m_req_valid_o never high.
- Assert rst_i during RD_CAPTURE of a partial store: no write_en pulse and no ack. After release, accept=1 and the model word is unchanged.
